// File: rtl/sphere_closest_hit_scan.sv
// rtl/sphere_closest_hit_scan.sv - sequential closest-hit scan over the sphere table, one index per cycle
module sphere_closest_hit_scan #(
    parameter int              NUM_SPHERES = 8,
    parameter int              PI_W        = 8,
    parameter int              T_W         = 32,
    parameter int              RAY_W       = 192,
    parameter logic [T_W-1:0]  T_MIN       = 32'h0000_028F,
    parameter logic [T_W-1:0]  T_MAX       = 32'h7FFF_FFFF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RAY_W-1:0]  in_ray,
    output logic [RAY_W-1:0]  ray_q,
    output logic [PI_W-1:0]   sph_index,
    input  logic              sph_hit,
    input  logic [T_W-1:0]    sph_t,
    input  logic [1:0]        sph_st,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_hit,
    output logic [T_W-1:0]    out_t,
    output logic [PI_W-1:0]   out_pi,
    output logic [1:0]        out_st,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PI_W-1:0] LAST_IDX = PI_W'(NUM_SPHERES - 1);

    state_t           state;
    state_t           next_state;
    logic             best_hit;
    logic [T_W-1:0]   best_t;
    logic [PI_W-1:0]  best_pi;
    logic [1:0]       best_st;
    logic             take;
    logic             last;

    // Strict less-than keeps the lower index on ties; the epsilon floor rejects zero/negative t.
    assign take = sph_hit
                  && ($signed(sph_t) > $signed(T_MIN))
                  && ($signed(sph_t) < $signed(best_t));
    assign last = (sph_index == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ray_q     <= '0;
            sph_index <= '0;
            best_hit  <= 1'b0;
            best_t    <= T_MAX;
            best_pi   <= '0;
            best_st   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ray_q     <= in_ray;
                        sph_index <= '0;
                        best_hit  <= 1'b0;
                        best_t    <= T_MAX;
                        best_pi   <= '0;
                        best_st   <= '0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_hit <= 1'b1;
                        best_t   <= sph_t;
                        best_pi  <= sph_index;
                        best_st  <= sph_st;
                    end
                    if (!last) begin
                        sph_index <= sph_index + PI_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sph_index <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_hit = best_hit;
    assign out_t   = best_t;
    assign out_pi  = best_pi;
    assign out_st  = best_st;

endmodule

// File: tb/tb_sphere_closest_hit_scan.sv
// tb/tb_sphere_closest_hit_scan.sv - randomized closest-hit scan bench against a table-driven reference model
module tb_sphere_closest_hit_scan;

    localparam int          NS    = 8;
    localparam logic [31:0] T_MIN = 32'h0000_028F;
    localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [191:0]  in_ray;
    logic [191:0]  ray_q;
    logic [7:0]    sph_index;
    logic          sph_hit;
    logic [31:0]   sph_t;
    logic [1:0]    sph_st;
    logic          out_valid;
    logic          out_ready;
    logic          out_hit;
    logic [31:0]   out_t;
    logic [7:0]    out_pi;
    logic [1:0]    out_st;
    logic          busy;

    logic          tbl_hit [NS];
    logic [31:0]   tbl_t   [NS];
    logic [1:0]    tbl_st  [NS];

    logic          exp_hit;
    logic [31:0]   exp_t;
    logic [7:0]    exp_pi;
    logic [1:0]    exp_st;

    logic          res_hit;
    logic [31:0]   res_t;
    logic [7:0]    res_pi;

    int checks = 0;
    int errors = 0;

    sphere_closest_hit_scan #(
        .NUM_SPHERES(NS), .PI_W(8), .T_W(32), .RAY_W(192),
        .T_MIN(T_MIN), .T_MAX(T_MAX)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_ray(in_ray),
        .ray_q(ray_q), .sph_index(sph_index),
        .sph_hit(sph_hit), .sph_t(sph_t), .sph_st(sph_st),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_t(out_t), .out_pi(out_pi), .out_st(out_st),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaves as the combinational evaluator: table lookup at the requested index.
    always_comb begin
        sph_hit = tbl_hit[sph_index[2:0]];
        sph_t   = tbl_t[sph_index[2:0]];
        sph_st  = tbl_st[sph_index[2:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void clear_table();
        for (int i = 0; i < NS; i++) begin
            tbl_hit[i] = 1'b0;
            tbl_t[i]   = 32'h0;
            tbl_st[i]  = 2'd0;
        end
    endfunction

    function automatic void random_table();
        for (int i = 0; i < NS; i++) begin
            tbl_hit[i] = 1'($urandom_range(0, 1));
            tbl_st[i]  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       tbl_t[i] = 32'($urandom_range(0, 7)) << 16;
                1:       tbl_t[i] = 32'($urandom_range(32'h280, 32'h2A0));
                2:       tbl_t[i] = 32'h0 - (32'($urandom_range(0, 5)) << 16);
                default: tbl_t[i] = $urandom;
            endcase
        end
    endfunction

    // Nearest strictly-closer hit beyond the epsilon, first index wins on equal distance.
    function automatic void model();
        longint best;
        exp_hit = 1'b0;
        exp_t   = T_MAX;
        exp_pi  = 8'd0;
        exp_st  = 2'd0;
        best    = longint'($signed(T_MAX));
        for (int i = 0; i < NS; i++) begin
            longint t = longint'($signed(tbl_t[i]));
            if (tbl_hit[i] && t > longint'($signed(T_MIN)) && t < best) begin
                best    = t;
                exp_hit = 1'b1;
                exp_t   = tbl_t[i];
                exp_pi  = 8'(i);
                exp_st  = tbl_st[i];
            end
        end
    endfunction

    // Starts and ends just after a falling edge.
    task automatic run_ray(input int hold, input bit next_valid);
        logic [191:0] r;
        int cnt;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = $urandom;
        model();
        in_valid = 1'b1;
        in_ray   = r;
        check("accept_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_ray   = '0;
        check("ray_latched", ray_q, r);
        check("busy_scan", busy, 1'b1);
        cnt = 1;
        while (!out_valid && cnt < 50) begin
            check("scan_index", sph_index, 64'(cnt - 1));
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, NS + 1);
        res_hit = out_hit;
        res_t   = out_t;
        res_pi  = out_pi;
        check("out_hit", out_hit, exp_hit);
        check("out_t", out_t, exp_t);
        check("out_pi", out_pi, exp_pi);
        check("out_st", out_st, exp_st);
        check("done_in_ready", in_ready, 1'b0);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_t", out_t, exp_t);
            check("hold_pi", out_pi, exp_pi);
            check("hold_hit", out_hit, exp_hit);
        end
        out_ready = 1'b1;
        if (next_valid) begin
            in_valid = 1'b1;
            for (int k = 0; k < 6; k++) in_ray[k*32 +: 32] = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_busy", busy, 1'b0);
        check("post_index", sph_index, 8'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_ray    = '0;
        out_ready = 1'b0;
        clear_table();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_hit", out_hit, 1'b0);
        check("rst_t", out_t, T_MAX);
        check("rst_pi", out_pi, 8'd0);
        check("rst_st", out_st, 2'd0);
        check("rst_index", sph_index, 8'd0);
        check("rst_ray", ray_q, 192'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Reset during SCAN cycle 3 discards the ray.
        clear_table();
        tbl_hit[0] = 1'b1; tbl_t[0] = 32'h0001_0000; tbl_st[0] = 2'd2;
        in_valid = 1'b1;
        in_ray   = {6{32'hA5A5_1234}};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_index", sph_index, 8'd2);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("mid_in_ready", in_ready, 1'b1);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_t", out_t, T_MAX);
        check("mid_hit", out_hit, 1'b0);
        check("mid_ray", ray_q, 192'd0);
        repeat (NS + 3) begin
            @(negedge clk);
            check("mid_no_result", out_valid, 1'b0);
        end

        clear_table();
        run_ray(0, 1'b0);
        check("nohit_hit", res_hit, 1'b0);
        check("nohit_t", res_t, T_MAX);

        clear_table();
        tbl_hit[2] = 1'b1; tbl_t[2] = 32'h0005_0000; tbl_st[2] = 2'd1;
        tbl_hit[6] = 1'b1; tbl_t[6] = 32'h0002_0000; tbl_st[6] = 2'd3;
        run_ray(1, 1'b0);
        check("two_pi", res_pi, 8'd6);
        check("two_t", res_t, 32'h0002_0000);

        clear_table();
        tbl_hit[1] = 1'b1; tbl_t[1] = 32'h0003_0000; tbl_st[1] = 2'd1;
        tbl_hit[4] = 1'b1; tbl_t[4] = 32'h0003_0000; tbl_st[4] = 2'd2;
        run_ray(0, 1'b0);
        check("tie_pi", res_pi, 8'd1);

        clear_table();
        tbl_hit[0] = 1'b1; tbl_t[0] = 32'h0000_0100;
        tbl_hit[3] = 1'b1; tbl_t[3] = 32'hFFFF_0000;
        tbl_hit[5] = 1'b1; tbl_t[5] = T_MIN;
        run_ray(0, 1'b0);
        check("eps_hit", res_hit, 1'b0);

        clear_table();
        tbl_hit[3] = 1'b1; tbl_t[3] = 32'h0004_0000; tbl_st[3] = 2'd2;
        run_ray(5, 1'b1);
        check("bp_second_pending", in_valid, 1'b1);

        clear_table();
        tbl_hit[7] = 1'b1; tbl_t[7] = 32'h0001_0000; tbl_st[7] = 2'd3;
        run_ray(0, 1'b0);
        check("last_pi", res_pi, 8'd7);
        check("last_t", res_t, 32'h0001_0000);

        for (int n = 0; n < 40; n++) begin
            random_table();
            run_ray($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
